// File: rtl/pkt_stats_regs.sv
// pkt_stats_regs: inline packet/word/byte statistics on a user data path, served
// to software over the UDP register ring.
//
// The data path passes through combinationally. A two-state framer separates
// module headers from packet words so that only real packet bytes are counted.
// The register ring is re-timed by one stage. Accesses that hit this block are
// acked and answered here. All other ring traffic is forwarded unchanged.
//
// Optional feature: define PKT_STATS_SATURATE_EN to make every counter stick at
// 0xFFFFFFFF instead of wrapping modulo 2^32.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module pkt_stats_regs #(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned UDP_REG_SRC_WIDTH = 2,
  parameter logic [`UDP_REG_ADDR_WIDTH-3:0] REG_BLOCK_TAG = 'h000010
) (
  input  logic                            clk,
  input  logic                            reset,

  // Upstream data path
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic                            in_wr,
  output logic                            in_rdy,

  // Downstream data path
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic                            out_wr,
  input  logic                            out_rdy,

  // Register ring in
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,

  // Register ring out (registered)
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);

  localparam int unsigned AddrW = `UDP_REG_ADDR_WIDTH;
  localparam int unsigned RegW  = `CPCI_NF2_DATA_WIDTH;

  // Register word indices within the block
  localparam logic [1:0] IdxPktCnt  = 2'd0;
  localparam logic [1:0] IdxWordCnt = 2'd1;
  localparam logic [1:0] IdxByteCnt = 2'd2;
  localparam logic [1:0] IdxCtrl    = 2'd3;

  typedef enum logic [0:0] {
    StHdrs = 1'b0,
    StPkt  = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pkt_cnt_q,  pkt_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic        en_q,       en_d;

  // Bytes carried by a last word: the highest set ctrl bit marks the final
  // valid byte lane, so 0x80 means one byte and 0x01 means a full word.
  function automatic logic [31:0] last_bytes(input logic [CTRL_WIDTH-1:0] c);
    logic [31:0] n;
    n = 32'(CTRL_WIDTH);
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      if (c[i]) n = 32'(CTRL_WIDTH - i);
    end
    return n;
  endfunction

  // Counter addition, wrapping or saturating depending on the build.
  function automatic logic [31:0] cnt_add(input logic [31:0] a, input logic [31:0] b);
`ifdef PKT_STATS_SATURATE_EN
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return a + b;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Data path: zero-latency pass-through; this stage never adds back-pressure.
  // ---------------------------------------------------------------------------
  assign out_data = in_data;
  assign out_ctrl = in_ctrl;
  assign out_wr   = in_wr;
  assign in_rdy   = out_rdy;

  logic xfer;
  logic ctrl_zero;
  logic is_data;
  logic is_last;

  assign xfer      = in_wr & out_rdy;
  assign ctrl_zero = (in_ctrl == '0);
  assign is_data   = xfer & ctrl_zero;
  // A non-zero ctrl word only ends a packet once data has started; before
  // that it is a module header.
  assign is_last   = xfer & ~ctrl_zero & (state_q == StPkt);

  // ---------------------------------------------------------------------------
  // Register ring decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic       ctrl_wr;
  logic       clr;
  logic [1:0] reg_idx;

  assign hit     = reg_req_in & ~reg_ack_in &
                   (reg_addr_in[AddrW-1:2] == REG_BLOCK_TAG);
  assign reg_idx = reg_addr_in[1:0];
  assign ctrl_wr = hit & ~reg_rd_wr_L_in & (reg_idx == IdxCtrl);
  assign clr     = ctrl_wr & reg_data_in[0];

  // Read mux: samples current register values, so a read concurrent with an
  // increment returns the pre-increment count.
  logic [RegW-1:0] rd_data;

  always_comb begin
    rd_data = '0;
    unique case (reg_idx)
      IdxPktCnt:  rd_data = RegW'(pkt_cnt_q);
      IdxWordCnt: rd_data = RegW'(word_cnt_q);
      IdxByteCnt: rd_data = RegW'(byte_cnt_q);
      IdxCtrl:    rd_data = RegW'({en_q, 1'b0});
      default:    rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Framer: tracks whether we are between packets (headers) or inside one.
  // It runs regardless of en so framing stays correct while counting is off.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHdrs;
    end else if (xfer) begin
      unique case (state_q)
        StHdrs:  if (ctrl_zero) state_q <= StPkt;
        StPkt:   if (!ctrl_zero) state_q <= StHdrs;
        default: state_q <= StHdrs;
      endcase
    end
  end

  // Next-state counters and enable; a clear write beats any same-cycle
  // increment, and a new en value only gates increments from the next cycle.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    en_d       = ctrl_wr ? reg_data_in[1] : en_q;

    if (clr) begin
      pkt_cnt_d  = '0;
      word_cnt_d = '0;
      byte_cnt_d = '0;
    end else if (en_q) begin
      if (is_last) pkt_cnt_d  = cnt_add(pkt_cnt_q, 32'd1);
      if (xfer)    word_cnt_d = cnt_add(word_cnt_q, 32'd1);
      if (is_data) begin
        byte_cnt_d = cnt_add(byte_cnt_q, 32'(CTRL_WIDTH));
      end else if (is_last) begin
        byte_cnt_d = cnt_add(byte_cnt_q, last_bytes(in_ctrl));
      end
    end
  end

  // Counter and enable state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      en_q       <= 1'b1;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      en_q       <= en_d;
    end
  end

  // Ring re-timing stage: forward everything, answer accesses that hit us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_ack_out     <= reg_ack_in | hit;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_data_out    <= (hit && reg_rd_wr_L_in) ? rd_data : reg_data_in;
      reg_src_out     <= reg_src_in;
    end
  end

endmodule

// File: tb/tb_pkt_stats_regs.sv
// Bench for pkt_stats_regs: directed data-path and ring stimulus; expected ring
// responses are queued at issue time and checked by an independent monitor.

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_pkt_stats_regs;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int DW = `CPCI_NF2_DATA_WIDTH;
  localparam logic [AW-3:0] TAG = 'h000010;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   in_data = '0;
  logic [7:0]    in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [63:0]   out_data;
  logic [7:0]    out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic          reg_req_in = 1'b0;
  logic          reg_ack_in = 1'b0;
  logic          reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [1:0]    reg_src_in = '0;
  logic          reg_req_out;
  logic          reg_ack_out;
  logic          reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0]    reg_src_out;

  typedef struct packed {
    logic          ack;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    src;
  } ring_t;

  ring_t exp_q[$];
  string name_q[$];
  ring_t mon_got;
  ring_t mon_exp;
  string mon_name;
  int    checks = 0;
  int    errors = 0;

  pkt_stats_regs dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_ctrl         (in_ctrl),
    .in_wr           (in_wr),
    .in_rdy          (in_rdy),
    .out_data        (out_data),
    .out_ctrl        (out_ctrl),
    .out_wr          (out_wr),
    .out_rdy         (out_rdy),
    .reg_req_in      (reg_req_in),
    .reg_ack_in      (reg_ack_in),
    .reg_rd_wr_L_in  (reg_rd_wr_L_in),
    .reg_addr_in     (reg_addr_in),
    .reg_data_in     (reg_data_in),
    .reg_src_in      (reg_src_in),
    .reg_req_out     (reg_req_out),
    .reg_ack_out     (reg_ack_out),
    .reg_rd_wr_L_out (reg_rd_wr_L_out),
    .reg_addr_out    (reg_addr_out),
    .reg_data_out    (reg_data_out),
    .reg_src_out     (reg_src_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every request leaving the ring stage must match the next queued
  // expectation, field for field.
  always @(posedge clk) begin
    #1;
    if (!reset && reg_req_out) begin
      mon_got = {reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ring_unexpected: got %h, required no request", mon_got);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL %s: got ack=%b rd=%b addr=%h data=%h src=%h, required ack=%b rd=%b addr=%h data=%h src=%h",
                   mon_name, mon_got.ack, mon_got.rd, mon_got.addr, mon_got.data, mon_got.src,
                   mon_exp.ack, mon_exp.rd, mon_exp.addr, mon_exp.data, mon_exp.src);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Advance to the next falling edge and return all inputs to idle.
  task automatic tick();
    @(negedge clk);
    in_wr = 1'b0;
    in_ctrl = '0;
    reg_req_in = 1'b0;
    reg_ack_in = 1'b0;
    reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0;
    reg_data_in = '0;
    reg_src_in = '0;
  endtask

  task automatic set_word(input logic [7:0] ctrl);
    in_wr = 1'b1;
    in_ctrl = ctrl;
    in_data = {$urandom, $urandom};
    #1;
    check("datapath_pass", {out_data[55:0], out_ctrl},
          {in_data[55:0], in_ctrl});
    check("datapath_wr_rdy", {62'd0, out_wr, in_rdy}, {62'd0, 1'b1, out_rdy});
  endtask

  task automatic send(input logic [7:0] ctrl);
    set_word(ctrl);
    tick();
  endtask

  task automatic set_rd(input logic [1:0] idx, input logic [31:0] exp, input string name);
    reg_req_in = 1'b1;
    reg_ack_in = 1'b0;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in = {TAG, idx};
    reg_data_in = $urandom;
    reg_src_in = idx ^ 2'd1;
    exp_q.push_back({1'b1, 1'b1, TAG, idx, exp, idx ^ 2'd1});
    name_q.push_back(name);
  endtask

  task automatic set_wr(input logic [1:0] idx, input logic [31:0] val);
    reg_req_in = 1'b1;
    reg_ack_in = 1'b0;
    reg_rd_wr_L_in = 1'b0;
    reg_addr_in = {TAG, idx};
    reg_data_in = val;
    reg_src_in = 2'd3;
    exp_q.push_back({1'b1, 1'b0, TAG, idx, val, 2'd3});
    name_q.push_back("write_echo");
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp, input string name);
    set_rd(idx, exp, name);
    tick();
  endtask

  task automatic rd_all(input logic [31:0] p, input logic [31:0] w, input logic [31:0] b);
    rd(2'd0, p, "pkt_cnt");
    rd(2'd1, w, "word_cnt");
    rd(2'd2, b, "byte_cnt");
  endtask

  initial begin
    // Reset state of the ring outputs
    #1;
    check("reset_ring_out", {reg_req_out, reg_ack_out, reg_rd_wr_L_out, 1'b0, reg_src_out},
          '0);
    check("reset_ring_addr_data", {9'd0, reg_addr_out, reg_data_out}, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Counters start at zero, en=1
    rd_all(32'd0, 32'd0, 32'd0);
    rd(2'd3, 32'd2, "ctrl_reset");

    // Header, three data words, last word ctrl 0x10 (4 bytes)
    send(8'hFF);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    send(8'h10);
    rd_all(32'd1, 32'd5, 32'd28);

    // Downstream stall: no transfers, no counts, back-pressure passed through
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_wr = 1'b1;
      in_ctrl = 8'h00;
      #1;
      check("stall_in_rdy", {63'd0, in_rdy}, 64'd0);
      tick();
    end
    out_rdy = 1'b1;
    rd_all(32'd1, 32'd5, 32'd28);

    // Already-acked access to our address is forwarded untouched
    reg_req_in = 1'b1;
    reg_ack_in = 1'b1;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in = {TAG, 2'd1};
    reg_data_in = 32'hDEAD_BEEF;
    reg_src_in = 2'd2;
    exp_q.push_back({1'b1, 1'b1, TAG, 2'd1, 32'hDEAD_BEEF, 2'd2});
    name_q.push_back("fwd_acked");
    tick();

    // Access to another block is forwarded without ack
    reg_req_in = 1'b1;
    reg_rd_wr_L_in = 1'b1;
    reg_addr_in = {TAG + 1'b1, 2'd0};
    reg_data_in = 32'h1234_5678;
    reg_src_in = 2'd1;
    exp_q.push_back({1'b0, 1'b1, TAG + 1'b1, 2'd0, 32'h1234_5678, 2'd1});
    name_q.push_back("fwd_miss");
    tick();

    // Read concurrent with an increment returns the old value; last ctrl 0x01 = 8 bytes
    set_rd(2'd1, 32'd5, "rd_during_inc");
    set_word(8'h00);
    tick();
    send(8'h00);
    send(8'h01);
    rd_all(32'd2, 32'd8, 32'd52);

    // Clear concurrent with a last word (0x80): clear wins, en stays 1
    send(8'h00);
    set_wr(2'd3, 32'h3);
    set_word(8'h80);
    tick();
    rd_all(32'd0, 32'd0, 32'd0);
    rd(2'd3, 32'd2, "ctrl_after_clr");

    // Disable in the same cycle as a header: that header still counts
    set_wr(2'd3, 32'h0);
    set_word(8'hFF);
    tick();
    rd(2'd3, 32'd0, "ctrl_disabled");
    send(8'h00);
    send(8'h80);
    rd_all(32'd0, 32'd1, 32'd0);

    // Re-enable; 8 + 8 + 1 bytes
    set_wr(2'd3, 32'h2);
    tick();
    send(8'h00);
    send(8'h00);
    send(8'h80);
    rd_all(32'd1, 32'd4, 32'd17);

    // Disable, enter a packet, then reset asynchronously mid-packet
    set_wr(2'd3, 32'h0);
    tick();
    set_word(8'h00);
    set_rd(2'd1, 32'd4, "rd_before_reset");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_ring", {reg_req_out, reg_ack_out, reg_data_out}, '0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // After reset: framer in HDRS, en=1; 0x40 last word = 2 bytes
    rd(2'd3, 32'd2, "ctrl_after_reset");
    send(8'hFF);
    send(8'h00);
    send(8'h40);
    rd_all(32'd1, 32'd3, 32'd10);

    tick();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
